adrv9001_tx_sample_ctrl: RTL and testbench

Transmit-side sample controller for the ADRV9001 SSI path. It sits directly upstream of the 32-bit-to-8-bit serdes unpacker. It sources one packed IQ word per unpacker request, from a DMA AXI-stream, an internal ramp, a fixed word or zeros. It also handles enable/burst sequencing and underflow accounting.

---
 rtl/adrv9001_tx_pkg.sv | 15 +
 rtl/adrv9001_tx_pattern_gen.sv | 35 +++
 rtl/adrv9001_tx_sample_ctrl.sv | 158 +++++++++++++++
 tb/tb_adrv9001_tx_sample_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_tx_pkg.sv
// Shared constants and types for the ADRV9001 transmit sample controller.
package adrv9001_tx_pkg;

    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_STREAM = 2'd1;
    localparam logic [1:0] MODE_RAMP   = 2'd2;
    localparam logic [1:0] MODE_FIXED  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/adrv9001_tx_pattern_gen.sv
// Internal word sources: zero, 16-bit ramp (I=r, Q=~r) and fixed word.
module adrv9001_tx_pattern_gen
    import adrv9001_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    input  logic [1:0]  mode,
    input  logic [31:0] fixed_data,
    output logic [31:0] word
);

    logic [15:0] ramp_q;

    // Ramp counter: cleared while idle, steps once per ramp word sent, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ramp_q <= '0;
        end else if (advance) begin
            ramp_q <= ramp_q + 16'd1;
        end
    end

    // Source mux; stream words are selected in the top level.
    always_comb begin
        word = '0;
        case (mode)
            MODE_RAMP:  word = {ramp_q, ~ramp_q};
            MODE_FIXED: word = fixed_data;
            default:    word = '0;
        endcase
    end

endmodule

// File: rtl/adrv9001_tx_sample_ctrl.sv
// Transmit sample controller: sources one IQ word per unpacker request and
// handles enable/burst sequencing and underflow accounting.
module adrv9001_tx_sample_ctrl
    import adrv9001_tx_pkg::*;
#(
    parameter int UFLOW_WIDTH = 16,
    parameter int LEN_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [LEN_WIDTH-1:0]   burst_len,
    input  logic [31:0]            fixed_data,
    input  logic [31:0]            s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   din_rdy,
    output logic [31:0]            dout,
    output logic                   active,
    output logic                   done,
    output logic                   uflow,
    output logic [UFLOW_WIDTH-1:0] uflow_cnt,
    input  logic                   uflow_clr
);

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            dout_q, dout_d;
    logic                   done_q, done_d;
    logic                   active_q;
    logic                   uflow_q;
    logic [UFLOW_WIDTH-1:0] ucnt_q;
    logic                   load;
    logic                   uflow_ev;
    logic                   term;
    logic [31:0]            pat_word;

    assign term = (len_q != '0) && (cnt_q == len_q);

    adrv9001_tx_pattern_gen u_pat (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == IDLE),
        .advance    (load && (mode_q == MODE_RAMP)),
        .mode       (mode_q),
        .fixed_data (fixed_data),
        .word       (pat_word)
    );

    // Next-state, datapath loads and stream handshake.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        dout_d        = dout_q;
        done_d        = 1'b0;
        load          = 1'b0;
        uflow_ev      = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = '0;
                cnt_d  = '0;
                if (enable) begin
                    mode_d  = mode;
                    len_d   = burst_len;
                    state_d = (mode == MODE_STREAM) ? PRIME : RUN;
                end
            end
            PRIME: begin
                s_axis_tready = din_rdy;
                // A word offered while tready is high is always taken, even if enable drops.
                if (din_rdy && s_axis_tvalid) begin
                    dout_d  = s_axis_tdata;
                    cnt_d   = LEN_WIDTH'(1);
                    state_d = RUN;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (din_rdy) begin
                    if (term) begin
                        dout_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (!enable) begin
                        dout_d  = '0;
                        state_d = IDLE;
                    end else begin
                        load  = 1'b1;
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                        if (mode_q == MODE_STREAM) begin
                            s_axis_tready = 1'b1;
                            if (s_axis_tvalid) begin
                                dout_d = s_axis_tdata;
                            end else begin
                                dout_d   = '0;
                                uflow_ev = 1'b1;
                            end
                        end else begin
                            dout_d = pat_word;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_ZERO;
            len_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            active_q <= (state_d != IDLE);
        end
    end

    // Sticky underflow flag and saturating counter; a coincident clear keeps the new event.
    always_ff @(posedge clk) begin
        if (rst) begin
            uflow_q <= 1'b0;
            ucnt_q  <= '0;
        end else if (uflow_clr) begin
            uflow_q <= uflow_ev;
            ucnt_q  <= uflow_ev ? UFLOW_WIDTH'(1) : '0;
        end else if (uflow_ev) begin
            uflow_q <= 1'b1;
            if (ucnt_q != '1) begin
                ucnt_q <= ucnt_q + UFLOW_WIDTH'(1);
            end
        end
    end

    assign dout      = dout_q;
    assign active    = active_q;
    assign done      = done_q;
    assign uflow     = uflow_q;
    assign uflow_cnt = ucnt_q;

endmodule

// File: tb/tb_adrv9001_tx_sample_ctrl.sv
// Self-checking bench for adrv9001_tx_sample_ctrl: directed table, hand
// sequences for multi-cycle corners and randomized traffic vs. a reference model.
module tb_adrv9001_tx_sample_ctrl;

    localparam int UW   = 16;
    localparam int LW   = 32;
    localparam int UMAX = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          rst, enable, s_axis_tvalid, s_axis_tready, din_rdy;
    logic          active, done, uflow, uflow_clr;
    logic [1:0]    mode;
    logic [LW-1:0] burst_len;
    logic [31:0]   fixed_data, s_axis_tdata, dout;
    logic [UW-1:0] uflow_cnt;

    always #5 clk = ~clk;

    adrv9001_tx_sample_ctrl #(.UFLOW_WIDTH(UW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .mode          (mode),
        .burst_len     (burst_len),
        .fixed_data    (fixed_data),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .din_rdy       (din_rdy),
        .dout          (dout),
        .active        (active),
        .done          (done),
        .uflow         (uflow),
        .uflow_cnt     (uflow_cnt),
        .uflow_clr     (uflow_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = stopped, 1 = waiting for first stream word, 2 = sending.
    int          m_state = 0;
    logic [1:0]  m_mode  = 2'd0;
    logic [LW-1:0] m_len = '0;
    logic [LW-1:0] m_cnt = '0;   // words sent in the current run
    logic [31:0] m_dout  = '0;
    bit          m_done  = 1'b0;
    bit          m_uf    = 1'b0;
    int          m_ucnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_term();
        return (m_len != 0) && (m_cnt == m_len);
    endfunction

    task automatic model_step();
        bit uev = 1'b0;
        logic [31:0] w;
        m_done = 1'b0;
        if (rst) begin
            m_state = 0; m_dout = '0; m_cnt = '0; m_uf = 1'b0; m_ucnt = 0;
            return;
        end
        case (m_state)
            0: begin
                m_dout = '0;
                m_cnt  = '0;
                if (enable) begin
                    m_mode  = mode;
                    m_len   = burst_len;
                    m_state = (mode == 2'd1) ? 1 : 2;
                end
            end
            1: begin
                if (din_rdy && s_axis_tvalid) begin
                    m_dout = s_axis_tdata; m_cnt = 1; m_state = 2;
                end else if (!enable) begin
                    m_state = 0;
                end
            end
            default: begin
                if (din_rdy) begin
                    if (m_term()) begin
                        m_dout = '0; m_state = 0; m_done = 1'b1;
                    end else if (!enable) begin
                        m_dout = '0; m_state = 0;
                    end else begin
                        case (m_mode)
                            2'd0: w = '0;
                            2'd1: begin
                                if (s_axis_tvalid) w = s_axis_tdata;
                                else begin w = '0; uev = 1'b1; end
                            end
                            2'd2: w = {m_cnt[15:0], ~m_cnt[15:0]};
                            default: w = fixed_data;
                        endcase
                        m_dout = w;
                        m_cnt  = m_cnt + 1;
                    end
                end
            end
        endcase
        if (uflow_clr) begin
            m_uf = uev; m_ucnt = uev ? 1 : 0;
        end else if (uev) begin
            m_uf = 1'b1;
            if (m_ucnt < UMAX) m_ucnt++;
        end
    endtask

    // One clock: check tready mid-cycle, advance model at the edge, check outputs after it.
    task automatic tick();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = din_rdy && ((m_state == 1) ||
                  ((m_state == 2) && (m_mode == 2'd1) && !m_term() && enable));
        chk("tready", s_axis_tready, exp_rdy);
        @(posedge clk);
        model_step();
        #1;
        chk("dout", dout, m_dout);
        chk("active", active, m_state != 0);
        chk("done", done, m_done);
        chk("uflow", uflow, m_uf);
        chk("uflow_cnt", uflow_cnt, m_ucnt);
    endtask

    typedef struct {
        bit          en;
        bit          dr;
        logic [31:0] dout;
        bit          act;
        bit          done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Fixed-mode burst of 3; enable drops on the terminating cycle.
        tbl[0] = '{1, 1, 32'hA5A55A5A, 1, 0};
        tbl[1] = '{1, 0, 32'hA5A55A5A, 1, 0};
        tbl[2] = '{1, 1, 32'hA5A55A5A, 1, 0};
        tbl[3] = '{1, 0, 32'hA5A55A5A, 1, 0};
        tbl[4] = '{1, 1, 32'hA5A55A5A, 1, 0};
        tbl[5] = '{1, 0, 32'hA5A55A5A, 1, 0};
        tbl[6] = '{0, 1, 32'h00000000, 0, 1};
        tbl[7] = '{0, 0, 32'h00000000, 0, 0};

        rst = 1'b1; enable = 1'b0; mode = 2'd0; burst_len = '0; fixed_data = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; din_rdy = 1'b0; uflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_active", active, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_uflow", uflow, 1'b0);
        chk("rst_ucnt", uflow_cnt, 0);
        chk("rst_tready", s_axis_tready, 1'b0);
        rst = 1'b0;
        tick();

        // Table-driven fixed burst.
        enable = 1'b1; mode = 2'd3; burst_len = 3; fixed_data = 32'hA5A55A5A;
        tick();
        chk("fix_start_active", active, 1'b1);
        for (int i = 0; i < 8; i++) begin
            enable = tbl[i].en; din_rdy = tbl[i].dr;
            tick();
            chk("tbl_dout", dout, tbl[i].dout);
            chk("tbl_active", active, tbl[i].act);
            chk("tbl_done", done, tbl[i].done);
        end

        // Continuous ramp, requested every cycle so the 16-bit wrap is reached quickly.
        enable = 1'b1; mode = 2'd2; burst_len = 0; din_rdy = 1'b0;
        tick();
        for (int i = 0; i < 65538; i++) begin
            din_rdy = 1'b1;
            tick();
            if (i == 0)     chk("ramp_w0", dout, 32'h0000FFFF);
            if (i == 1)     chk("ramp_w1", dout, 32'h0001FFFE);
            if (i == 65535) chk("ramp_last", dout, 32'hFFFF0000);
            if (i == 65536) chk("ramp_wrap", dout, 32'h0000FFFF);
        end
        // Enable drop mid continuous run: zero word, stop, no done.
        enable = 1'b0; din_rdy = 1'b1;
        tick();
        chk("stop_dout", dout, 32'h0);
        chk("stop_active", active, 1'b0);
        chk("stop_done", done, 1'b0);
        din_rdy = 1'b0; uflow_clr = 1'b1;
        tick();
        uflow_clr = 1'b0;

        // Stream prime: tvalid low for 10 cycles, no underflow.
        enable = 1'b1; mode = 2'd1; burst_len = 0; s_axis_tvalid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            din_rdy = (i % 2 == 0);
            tick();
        end
        chk("prime_active", active, 1'b1);
        chk("prime_uflow", uflow, 1'b0);
        din_rdy = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h12345678;
        tick();
        chk("prime_first", dout, 32'h12345678);
        enable = 1'b0; din_rdy = 1'b0; s_axis_tvalid = 1'b0;
        tick();
        din_rdy = 1'b1;
        tick();
        din_rdy = 1'b0;
        tick();

        // Stream burst of 8 with words 4 and 5 missing.
        enable = 1'b1; mode = 2'd1; burst_len = 8;
        tick();
        din_rdy = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h10000001;
        tick();
        for (int w = 2; w <= 8; w++) begin
            din_rdy = 1'b0;
            tick();
            din_rdy = 1'b1; s_axis_tvalid = (w != 4) && (w != 5); s_axis_tdata = 32'h10000000 + w;
            tick();
            if (w == 4 || w == 5) chk("uf_word_zero", dout, 32'h0);
        end
        din_rdy = 1'b0; s_axis_tvalid = 1'b1;
        tick();
        enable = 1'b0; din_rdy = 1'b1;
        tick();
        chk("burst8_done", done, 1'b1);
        chk("burst8_uflow", uflow, 1'b1);
        chk("burst8_ucnt", uflow_cnt, 2);
        din_rdy = 1'b0;
        tick();

        // Clear coincident with an underflow keeps the event.
        enable = 1'b1; mode = 2'd1; burst_len = 0;
        tick();
        din_rdy = 1'b1; s_axis_tvalid = 1'b1;
        tick();
        din_rdy = 1'b0;
        tick();
        din_rdy = 1'b1; s_axis_tvalid = 1'b0; uflow_clr = 1'b1;
        tick();
        chk("clr_uf_ucnt", uflow_cnt, 1);
        chk("clr_uf_flag", uflow, 1'b1);
        uflow_clr = 1'b0; enable = 1'b0; din_rdy = 1'b0;
        tick();
        din_rdy = 1'b1;
        tick();

        // Reset in the middle of a fixed burst.
        enable = 1'b1; mode = 2'd3; burst_len = 5; fixed_data = 32'hCAFEF00D; din_rdy = 1'b0;
        tick();
        din_rdy = 1'b1;
        tick();
        din_rdy = 1'b0;
        tick();
        din_rdy = 1'b1; rst = 1'b1;
        tick();
        chk("mrst_dout", dout, 32'h0);
        chk("mrst_active", active, 1'b0);
        chk("mrst_done", done, 1'b0);
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk("mrst_tready", s_axis_tready, 1'b0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            uflow_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            burst_len = LW'($urandom_range(0, 6));
            if ($urandom_range(0, 7) != 0) din_rdy = ~din_rdy;
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = $urandom;
            if ($urandom_range(0, 31) == 0) fixed_data = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
